// File: rtl/alu_share_arb.sv
//============================================================================
// Module   : alu_share_arb
// Purpose  : Shares one combinational simple_alu among NREQ requesters.
//            Arbitrates, registers the winner's operands/opcode onto the ALU,
//            captures the 8-bit result and returns it to the owning requester
//            over a valid/ready response channel. One transaction in flight.
// Ports    : clk, rst_n (async, active-low)
//            i_req_valid/o_req_ready/i_req_a/i_req_b/i_req_op : request side
//            o_alu_a/o_alu_b/o_alu_op/i_alu_result            : ALU side
//            o_rsp_valid/i_rsp_ready/o_rsp_data               : response side
//            o_busy : high whenever the FSM is not idle
// Config   : ALU_SHARE_ARB_RR_EN defined -> round-robin arbitration,
//            otherwise fixed priority (lowest index wins).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module alu_share_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 4,
  parameter int RW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]    i_req_valid,
  output logic [NREQ-1:0]    o_req_ready,
  input  logic [NREQ*DW-1:0] i_req_a,
  input  logic [NREQ*DW-1:0] i_req_b,
  input  logic [NREQ*2-1:0]  i_req_op,
  output logic [DW-1:0]      o_alu_a,
  output logic [DW-1:0]      o_alu_b,
  output logic [1:0]         o_alu_op,
  input  logic [RW-1:0]      i_alu_result,
  output logic [NREQ-1:0]    o_rsp_valid,
  input  logic [NREQ-1:0]    i_rsp_ready,
  output logic [RW-1:0]      o_rsp_data,
  output logic              o_busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic [IW-1:0]   r_owner;
  logic [DW-1:0]   r_alu_a;
  logic [DW-1:0]   r_alu_b;
  logic [1:0]      r_alu_op;
  logic [RW-1:0]   r_rsp_data;

  logic            w_grant_vld;
  logic [IW-1:0]   w_grant_idx;
  logic [NREQ-1:0] w_grant_oh;
  logic [NREQ-1:0] w_owner_oh;
  logic [DW-1:0]   w_sel_a;
  logic [DW-1:0]   w_sel_b;
  logic [1:0]      w_sel_op;
  logic            w_accept;
  logic            w_rsp_done;

`ifdef ALU_SHARE_ARB_RR_EN
  logic [IW-1:0]   r_ptr;

  // Search pointer+1, pointer+2, ... wrapping; first valid requester wins.
  always_comb begin
    int w_rr_j;
    w_rr_j      = 0;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_rr_j = int'(r_ptr) + k;
      if (w_rr_j >= NREQ) w_rr_j = w_rr_j - NREQ;
      if (!w_grant_vld && i_req_valid[IW'(w_rr_j)]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = IW'(w_rr_j);
      end
    end
  end
`else
  // Descending scan so the lowest valid index is the last (winning) assignment.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req_valid[i]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = IW'(i);
      end
    end
  end
`endif

  // Operand/opcode mux for the current winner.
  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == w_grant_idx) begin
        w_sel_a  = i_req_a[i*DW +: DW];
        w_sel_b  = i_req_b[i*DW +: DW];
        w_sel_op = i_req_op[i*2 +: 2];
      end
    end
  end

  assign w_grant_oh = {{(NREQ-1){1'b0}}, 1'b1} << w_grant_idx;
  assign w_owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
  assign w_accept   = (r_state == S_IDLE) && w_grant_vld;
  assign w_rsp_done = (r_state == S_RESP) && i_rsp_ready[r_owner];

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // FSM: next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_RESP;
      S_RESP:  if (w_rsp_done) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM: outputs. req_ready is gated by rst_n so it reads 0 while reset is held.
  always_comb begin
    o_req_ready = '0;
    o_rsp_valid = '0;
    o_busy      = (r_state != S_IDLE);
    if (rst_n && (r_state == S_IDLE) && w_grant_vld) o_req_ready = w_grant_oh;
    if (r_state == S_RESP)                           o_rsp_valid = w_owner_oh;
  end

  // Datapath: operand capture on accept, result capture at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner    <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_rsp_data <= '0;
`ifdef ALU_SHARE_ARB_RR_EN
      r_ptr      <= IW'(NREQ - 1);
`endif
    end else begin
      if (w_accept) begin
        r_owner  <= w_grant_idx;
        r_alu_a  <= w_sel_a;
        r_alu_b  <= w_sel_b;
        r_alu_op <= w_sel_op;
`ifdef ALU_SHARE_ARB_RR_EN
        r_ptr    <= w_grant_idx;
`endif
      end
      if (r_state == S_EXEC) r_rsp_data <= i_alu_result;
    end
  end

  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_op   = r_alu_op;
  assign o_rsp_data = r_rsp_data;

endmodule

`default_nettype wire

// File: doc/alu_share_arb.md
# alu_share_arb

Shared-access controller for the 4-bit `simple_alu` datapath: arbitrates among NREQ requesters, registers the winner's operands and opcode, drives the ALU, captures its 8-bit result and returns it to that requester over a valid/ready response channel. Sits between the requesting units and a single `simple_alu` instance, which stays purely combinational. One transaction is in flight at a time.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `DW`, 4, operand width; matches ALU `a`/`b`
- `RW`, 8, result width; matches ALU `result`
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NREQ  per-requester request valid
- `req_ready`  out  NREQ  per-requester accept, at most one bit set
- `req_a`  in  NREQ*DW  operand a, requester i at `[i*DW +: DW]`
- `req_b`  in  NREQ*DW  operand b, same packing
- `req_op`  in  NREQ*2  opcode, requester i at `[i*2 +: 2]`; 00 ADD, 01 SUB, 10 AND, 11 OR
- `alu_a`  out  DW  to ALU `a`, registered
- `alu_b`  out  DW  to ALU `b`, registered
- `alu_op`  out  2  to ALU `op`, registered
- `alu_result`  in  RW  from ALU `result`
- `rsp_valid`  out  NREQ  one-hot response valid to the owning requester
- `rsp_ready`  in  NREQ  per-requester response accept
- `rsp_data`  out  RW  captured result, shared by all requesters
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: the grant is computed combinationally from `req_valid` each cycle. `req_ready[g]`=1 only for the winner g, and only in IDLE. A handshake occurs on a rising edge with `req_valid[g]`&`req_ready[g]`. On that edge:
  - operands and opcode of g load into `alu_a`/`alu_b`/`alu_op`
  - owner index is latched
  - state goes to EXEC
- If no requester is valid, the FSM stays in IDLE. A requester may drop `req_valid` before it is accepted; the grant is recomputed.
- EXEC: the ALU evaluates the held operands. On the next edge `rsp_data` <= `alu_result` and state goes to RESP.
- RESP: `rsp_valid[owner]`=1, with `rsp_data` stable. On an edge with `rsp_ready[owner]`=1, `rsp_valid` clears and state goes to IDLE. `rsp_ready` bits of non-owners are ignored.
- `alu_*` and `rsp_data` hold their last values in IDLE; they are not cleared between transactions.
- The arbiter never alters data. Width behaviour is the ALU's: 8-bit context, so SUB wraps modulo 256 (3-5 = 8'hFE) and ADD carries into bit 4 (F+F = 8'h1E).
- Reset (asynchronous, any state, including mid-transaction) forces:
  - state = IDLE
  - `req_ready` = 0, `rsp_valid` = 0, `busy` = 0
  - `alu_a`/`alu_b`/`alu_op`/`rsp_data` = 0
  - arbitration pointer = NREQ-1
  - any in-flight transaction is discarded with no response.

## Timing
- Accept edge at cycle T. EXEC in cycle T+1. `rsp_valid` is high from cycle T+2.
- Minimum response latency: 2 cycles from the accept edge.
- Best-case throughput: one transaction per 3 cycles (accept, EXEC, RESP with `rsp_ready` already high), then IDLE. The next accept is possible in the cycle after RESP completes.
- `rsp_ready` low stalls indefinitely in RESP. No new request is accepted while stalled.
- `req_ready` is combinational from `req_valid` and state. There is no combinational path from `alu_result` or `rsp_ready` to any output.

## Configuration
- `ALU_SHARE_ARB_RR_EN` defined: round-robin arbitration.
  - Search starts at pointer+1, wrapping NREQ-1→0.
  - The pointer updates to the granted index on each accept only.
  - With reset pointer NREQ-1, requester 0 wins first.
- Not defined: fixed priority, lowest index wins. No pointer register exists.

## Test plan
- Single request: requester 1, a=3, b=5, op=00 accepted at T → `rsp_valid`=4'b0010 at T+2, `rsp_data`=8'h08, `busy` high T+1..T+2.
- ALU ops through the arbiter, one request each:
  - 8-3 SUB → 8'h05
  - F&5 AND → 8'h05
  - 3|C OR → 8'h0F
  - 3-5 SUB → 8'hFE
- All four valid continuously, `rsp_ready` all high:
  - with `ALU_SHARE_ARB_RR_EN`, grant order is 0,1,2,3,0, one accept every 3 cycles
  - without it, requester 0 wins every time
- Backpressure: hold `rsp_ready[owner]`=0 for 5 cycles → `rsp_valid` and `rsp_data` stay stable, `req_ready`=0 throughout, completion on the first cycle it goes high.
- Reset mid-EXEC: pull `rst_n` low → all outputs go to 0 immediately. After release, a new request from requester 2 completes normally; in RR mode requester 0 has priority again.
- Valid withdrawn: requester 3 asserts then drops `req_valid` while requester 1 becomes valid in the same IDLE cycle → only requester 1 is accepted and `req_ready[3]` is never sampled high.
